// File: rtl/i2c_apb_rd_pipe_if.sv
// APB slave-side bundle for the I2C read pipe: request fields in, registered response out.
interface i2c_apb_rd_pipe_if #(
    parameter int AW = 12
);
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [31:0]   prdata;
    logic          pready;
    logic          pslverr;

    modport master (
        output psel, penable, pwrite, paddr,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/i2c_apb_rd_pipe.sv
// Registered multi-channel APB read mux for the I2C banks: pready 2+RD_WS cycles after setup, prdata from a flop.
// Optional RX FIFO pop strobe on RXDATA reads is enabled by defining I2C_APB_RXPOP_EN.
module i2c_apb_rd_pipe #(
    parameter int NCH   = 2,
    parameter int AW    = 12,
    parameter int RD_WS = 0
) (
    input  logic              pclk,
    input  logic              preset,
    i2c_apb_rd_pipe_if.slave  apb,
    input  logic [8*NCH-1:0]  rx_data,
    input  logic [10*NCH-1:0] status,
    input  logic [32*NCH-1:0] control,
    input  logic [6*NCH-1:0]  clkdivhi,
    input  logic [6*NCH-1:0]  clkdivlo,
    input  logic [31:0]       id,
    output logic [NCH-1:0]    rx_pop
);
    localparam int             CW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [1:0]     WS    = 2'(RD_WS);
    localparam logic [CW:0]    NCH_L = (CW+1)'(NCH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    r_state;
    logic [1:0]    r_cnt;
    logic [31:0]   r_prdata;
    logic          r_pready;
    logic          r_pslverr;

    logic [CW-1:0] w_ch;
    logic [7:0]    w_off;
    logic          w_oor;
    logic          w_start;
    logic          w_wait_last;
    logic          w_to_done;
    logic [7:0]    w_rx;
    logic [9:0]    w_st;
    logic [31:0]   w_ctl;
    logic [5:0]    w_hi;
    logic [5:0]    w_lo;
    logic [31:0]   w_rd_val;

    assign w_ch        = apb.paddr[8+CW-1:8];
    assign w_off       = apb.paddr[7:0];
    assign w_oor       = {1'b0, w_ch} >= NCH_L;
    assign w_start     = apb.psel && !apb.penable;
    assign w_wait_last = (r_cnt == WS - 2'd1);
    // Capture happens on the edge that enters DONE, so inputs are sampled as late as possible.
    assign w_to_done   = apb.psel &&
                         (((r_state == S_SETUP) && (WS == 2'd0)) ||
                          ((r_state == S_WAIT) && w_wait_last));

    generate
        if (AW > 8 + CW) begin : g_hi_addr
            logic w_unused_hi;
            assign w_unused_hi = ^apb.paddr[AW-1:8+CW];
        end
    endgenerate

    always_comb begin
        w_rx  = '0;
        w_st  = '0;
        w_ctl = '0;
        w_hi  = '0;
        w_lo  = '0;
        for (int n = 0; n < NCH; n++) begin
            if (w_ch == CW'(n)) begin
                w_rx  = rx_data[8*n +: 8];
                w_st  = status[10*n +: 10];
                w_ctl = control[32*n +: 32];
                w_hi  = clkdivhi[6*n +: 6];
                w_lo  = clkdivlo[6*n +: 6];
            end
        end
    end

    always_comb begin
        w_rd_val = '0;
        case (w_off)
            8'h00:   w_rd_val = {24'h0, w_rx};
            8'h04:   w_rd_val = {22'h0, w_st};
            8'h08:   w_rd_val = w_ctl;
            8'h0C:   w_rd_val = {26'h0, w_hi};
            8'h10:   w_rd_val = {26'h0, w_lo};
            8'h14:   w_rd_val = id;
            default: w_rd_val = '0;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
        end else begin
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_start) r_state <= S_SETUP;
                end
                S_SETUP: begin
                    r_cnt <= '0;
                    if (!apb.psel)          r_state <= S_IDLE;
                    else if (WS == 2'd0)    r_state <= S_DONE;
                    else                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!apb.psel) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (w_wait_last) begin
                        r_state <= S_DONE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= (r_cnt == WS) ? r_cnt : r_cnt + 2'd1;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= w_start ? S_SETUP : S_IDLE;
                end
            endcase
            if (w_to_done) begin
                r_pready  <= 1'b1;
                r_pslverr <= w_oor;
                r_prdata  <= (apb.pwrite || w_oor) ? 32'h0 : w_rd_val;
            end
        end
    end

    assign apb.prdata  = r_prdata;
    assign apb.pready  = r_pready;
    assign apb.pslverr = r_pslverr;

`ifdef I2C_APB_RXPOP_EN
    logic [NCH-1:0] r_rx_pop;

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_rx_pop <= '0;
        end else begin
            for (int n = 0; n < NCH; n++) begin
                r_rx_pop[n] <= w_to_done && !apb.pwrite && !w_oor &&
                               (w_off == 8'h00) && (w_ch == CW'(n));
            end
        end
    end

    assign rx_pop = r_rx_pop;
`else
    assign rx_pop = '0;
`endif
endmodule

// File: tb/tb_i2c_apb_rd_pipe.sv
// Scoreboard bench: two pipes (NCH=2/RD_WS=0 and NCH=3/RD_WS=3) driven with directed APB transfers.
module tb_i2c_apb_rd_pipe;
    localparam int WS_A = 0;
    localparam int WS_B = 3;
`ifdef I2C_APB_RXPOP_EN
    localparam bit POP_EN = 1'b1;
`else
    localparam bit POP_EN = 1'b0;
`endif

    localparam logic [31:0] ID   = 32'hC0DE_0012;
    localparam logic [15:0] RXA  = {8'h81, 8'h3C};
    localparam logic [19:0] STA  = {10'h155, 10'h3FF};
    localparam logic [63:0] CTLA = {32'hA5A5_0003, 32'h1234_5678};
    localparam logic [11:0] HIA  = {6'h15, 6'h2A};
    localparam logic [11:0] LOA  = {6'h3E, 6'h11};
    localparam logic [23:0] RXB  = {8'hE7, 8'h5A, 8'h3C};
    localparam logic [29:0] STB  = {10'h001, 10'h2AA, 10'h0F0};
    localparam logic [95:0] CTLB = {32'h8000_0000, 32'h0000_0001, 32'hDEAD_BEEF};
    localparam logic [17:0] HIB  = {6'h3F, 6'h20, 6'h01};
    localparam logic [17:0] LOB  = {6'h0C, 6'h3A, 6'h05};

    typedef struct {
        logic [31:0] dat;
        logic        err;
        logic [7:0]  pop;
        int          done;
    } exp_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_v  [2];
    logic        psel_v [2];
    logic        pen_v  [2];
    logic        pwr_v  [2];
    logic [11:0] addr_v [2];
    logic [31:0] dat_o  [2];
    logic        rdy_o  [2];
    logic        err_o  [2];
    logic [7:0]  pop_o  [2];
    logic [1:0]  pop_a;
    logic [2:0]  pop_b;

    int          n_chk  = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    logic [31:0] last   [2];
    exp_t        q0[$];
    exp_t        q1[$];

    i2c_apb_rd_pipe_if #(.AW(12)) ifa ();
    i2c_apb_rd_pipe_if #(.AW(12)) ifb ();

    assign ifa.psel    = psel_v[0];
    assign ifa.penable = pen_v[0];
    assign ifa.pwrite  = pwr_v[0];
    assign ifa.paddr   = addr_v[0];
    assign ifb.psel    = psel_v[1];
    assign ifb.penable = pen_v[1];
    assign ifb.pwrite  = pwr_v[1];
    assign ifb.paddr   = addr_v[1];
    assign dat_o[0]    = ifa.prdata;
    assign rdy_o[0]    = ifa.pready;
    assign err_o[0]    = ifa.pslverr;
    assign dat_o[1]    = ifb.prdata;
    assign rdy_o[1]    = ifb.pready;
    assign err_o[1]    = ifb.pslverr;
    assign pop_o[0]    = {6'd0, pop_a};
    assign pop_o[1]    = {5'd0, pop_b};

    i2c_apb_rd_pipe #(.NCH(2), .AW(12), .RD_WS(WS_A)) dut_a (
        .pclk(clk), .preset(rst_v[0]), .apb(ifa),
        .rx_data(RXA), .status(STA), .control(CTLA),
        .clkdivhi(HIA), .clkdivlo(LOA), .id(ID), .rx_pop(pop_a)
    );

    i2c_apb_rd_pipe #(.NCH(3), .AW(12), .RD_WS(WS_B)) dut_b (
        .pclk(clk), .preset(rst_v[1]), .apb(ifb),
        .rx_data(RXB), .status(STB), .control(CTLB),
        .clkdivhi(HIB), .clkdivlo(LOB), .id(ID), .rx_pop(pop_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops an expectation on every pready, otherwise checks the quiet-cycle outputs.
    always @(negedge clk) begin
        exp_t e;
        bit   have;
        if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                if (rdy_o[k]) begin
                    have = 1'b0;
                    if (k == 0 && q0.size() > 0) begin
                        e = q0.pop_front();
                        have = 1'b1;
                    end else if (k == 1 && q1.size() > 0) begin
                        e = q1.pop_front();
                        have = 1'b1;
                    end
                    if (!have) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_pready inst%0d: got pready=1 expected 0 (cycle %0d)", k, cyc);
                    end else begin
                        chk($sformatf("prdata[%0d]", k), dat_o[k], e.dat);
                        chk($sformatf("pslverr[%0d]", k), {31'd0, err_o[k]}, {31'd0, e.err});
                        chk($sformatf("rx_pop[%0d]", k), {24'd0, pop_o[k]}, {24'd0, e.pop});
                        chk($sformatf("done_cycle[%0d]", k), 32'(cyc), 32'(e.done));
                        last[k] = e.dat;
                    end
                end else begin
                    chk($sformatf("quiet_err_pop[%0d]", k), {23'd0, err_o[k], pop_o[k]}, 32'd0);
                    chk($sformatf("prdata_hold[%0d]", k), dat_o[k], last[k]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input int k, input logic [11:0] a, input logic wr,
                        input logic [31:0] d, input logic er, input logic [7:0] pm,
                        input bit chain);
        exp_t e;
        int   ws;
        bit   got;
        ws = (k == 0) ? WS_A : WS_B;
        psel_v[k] = 1'b1;
        pen_v[k]  = 1'b0;
        pwr_v[k]  = wr;
        addr_v[k] = a;
        e.dat  = d;
        e.err  = er;
        e.pop  = POP_EN ? pm : 8'd0;
        e.done = cyc + 2 + ws;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
        step();
        pen_v[k] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            step();
            got = rdy_o[k];
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout inst%0d addr %h: got no pready expected pready within 12 cycles", k, a);
        end
        if (!chain) begin
            psel_v[k] = 1'b0;
            pen_v[k]  = 1'b0;
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_v[k]  = 1'b1;
            psel_v[k] = 1'b0;
            pen_v[k]  = 1'b0;
            pwr_v[k]  = 1'b0;
            addr_v[k] = '0;
            last[k]   = '0;
        end
        repeat (3) step();
        rst_v[0] = 1'b0;
        rst_v[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset_prdata[%0d]", k), dat_o[k], 32'd0);
            chk($sformatf("reset_pready[%0d]", k), {31'd0, rdy_o[k]}, 32'd0);
            chk($sformatf("reset_pslverr[%0d]", k), {31'd0, err_o[k]}, 32'd0);
            chk($sformatf("reset_rx_pop[%0d]", k), {24'd0, pop_o[k]}, 32'd0);
        end
        mon_en = 1'b1;
        step();

        // Instance A: NCH=2, no wait states.
        xfer(0, 12'h108, 1'b0, 32'hA5A5_0003, 1'b0, 8'h00, 1'b0);
        xfer(0, 12'h004, 1'b0, 32'h0000_03FF, 1'b0, 8'h00, 1'b1);
        xfer(0, 12'h00C, 1'b0, 32'h0000_002A, 1'b0, 8'h00, 1'b0);
        xfer(0, 12'h214, 1'b0, ID,            1'b0, 8'h00, 1'b0);
        xfer(0, 12'h000, 1'b0, 32'h0000_003C, 1'b0, 8'h01, 1'b0);
        xfer(0, 12'h100, 1'b0, 32'h0000_0081, 1'b0, 8'h02, 1'b0);
        xfer(0, 12'h018, 1'b0, 32'h0000_0000, 1'b0, 8'h00, 1'b0);
        xfer(0, 12'h110, 1'b0, 32'h0000_003E, 1'b0, 8'h00, 1'b0);
        xfer(0, 12'h108, 1'b1, 32'h0000_0000, 1'b0, 8'h00, 1'b0);
        xfer(0, 12'h008, 1'b0, 32'h1234_5678, 1'b0, 8'h00, 1'b0);
        xfer(0, 12'h000, 1'b1, 32'h0000_0000, 1'b0, 8'h00, 1'b0);
        step();

        // Instance B: NCH=3, three wait states.
        xfer(1, 12'h000, 1'b0, 32'h0000_003C, 1'b0, 8'h01, 1'b0);
        xfer(1, 12'h314, 1'b0, 32'h0000_0000, 1'b1, 8'h00, 1'b0);
        xfer(1, 12'h200, 1'b0, 32'h0000_00E7, 1'b0, 8'h04, 1'b0);
        xfer(1, 12'h208, 1'b0, 32'h8000_0000, 1'b0, 8'h00, 1'b0);
        xfer(1, 12'h104, 1'b0, 32'h0000_02AA, 1'b0, 8'h00, 1'b1);
        xfer(1, 12'h10C, 1'b0, 32'h0000_0020, 1'b0, 8'h00, 1'b0);
        xfer(1, 12'h300, 1'b0, 32'h0000_0000, 1'b1, 8'h00, 1'b0);

        // psel dropped mid-WAIT: nothing may complete, and the next read must see normal latency.
        psel_v[1] = 1'b1;
        pen_v[1]  = 1'b0;
        pwr_v[1]  = 1'b0;
        addr_v[1] = 12'h000;
        step();
        pen_v[1] = 1'b1;
        repeat (2) step();
        psel_v[1] = 1'b0;
        pen_v[1]  = 1'b0;
        repeat (3) step();
        xfer(1, 12'h014, 1'b0, ID, 1'b0, 8'h00, 1'b0);
        step();

        // Reset on the edge that would otherwise enter DONE for an RXDATA read.
        psel_v[1] = 1'b1;
        pen_v[1]  = 1'b0;
        addr_v[1] = 12'h100;
        step();
        pen_v[1] = 1'b1;
        repeat (3) step();
        rst_v[1] = 1'b1;
        step();
        rst_v[1]  = 1'b0;
        psel_v[1] = 1'b0;
        pen_v[1]  = 1'b0;
        last[1]   = 32'd0;
        chk("midreset_prdata", dat_o[1], 32'd0);
        chk("midreset_pready", {31'd0, rdy_o[1]}, 32'd0);
        chk("midreset_pslverr", {31'd0, err_o[1]}, 32'd0);
        chk("midreset_rx_pop", {24'd0, pop_o[1]}, 32'd0);
        step();
        xfer(1, 12'h210, 1'b0, 32'h0000_000C, 1'b0, 8'h00, 1'b0);

        repeat (5) step();
        chk("scoreboard_empty", 32'(q0.size() + q1.size()), 32'd0);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
